hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_fwd_unit.sv | 35 +++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

   // Memory-wait sequencer states.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   // EX operand source select.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX operand: MEM result wins over WB result.
module fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   // Register 0 is hardwired, so a write to it never produces a forwardable value.
   assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
   assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);

   // Pick the youngest producer; interlock-only builds always read the register file.
   always_comb begin
      sel = FWD_RF;
      if (FWD_EN != 0) begin
         if (mem_hit) begin
            sel = FWD_MEM;
         end else if (wb_hit) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use / interlock stalls,
// branch flushes and a memory-wait sequencer with timeout.
//
// state       | meaning
// ST_RUN      | no outstanding data-memory access, pipeline free to advance
// ST_MEM_WAIT | data-memory access pending, whole pipeline held
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int FWD_EN      = 1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic              ex_pc_sel,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              stall_front,
   output logic              stall_back,
   output logic              flush_id,
   output logic              flush_ex,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              mem_timeout_err,
   output logic [31:0]       perf_stall_cnt
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             ex_hit;
   logic             mem_hit;
   logic             wb_hit;
   logic             load_use;
   logic             raw_stall;
   logic             mem_stall;

   fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
      .rs           (ex_rs1),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_a_sel)
   );

   fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
      .rs           (ex_rs2),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_b_sel)
   );

   function automatic logic id_reads(input logic [REG_AW-1:0] rd, input logic we,
                                     input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
      return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

   // RAW detection against every in-flight producer; which ones matter depends on FWD_EN.
   always_comb begin
      ex_hit    = id_reads(ex_rd, ex_regwrite, id_rs1, id_rs2);
      mem_hit   = id_reads(mem_rd, mem_regwrite, id_rs1, id_rs2);
      wb_hit    = id_reads(wb_rd, wb_regwrite, id_rs1, id_rs2);
      load_use  = ex_is_load && ex_hit;
      raw_stall = (FWD_EN != 0) ? load_use : (ex_hit || mem_hit || wb_hit);
   end

   // A miss is stalled in the very cycle it is seen, not one cycle late.
   always_comb begin
      mem_stall = 1'b0;
      if (state == ST_RUN) begin
         mem_stall = mem_req && !mem_ready;
      end else begin
         mem_stall = !mem_ready;
      end
   end

   // Priority: memory stall, then branch flush, then RAW stall. A branch held
   // during a memory stall is flushed once the stall drops.
   always_comb begin
      stall_back  = mem_stall;
      stall_front = mem_stall || (!ex_pc_sel && raw_stall);
      flush_id    = !mem_stall && ex_pc_sel;
      flush_ex    = !mem_stall && (ex_pc_sel || raw_stall);
   end

   // Memory-wait sequencer with wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_RUN;
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= CNT_ONE;
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == CNT_MAX) begin
                  state           <= ST_RUN;
                  wait_cnt        <= '0;
                  mem_timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Saturating count of front-end stall cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
      end else if (stall_front && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: one forwarding build (MEM_TIMEOUT = 4)
// and one interlock-only build share the same stimulus.
module tb_hazard_ctrl;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite;
   logic        ex_pc_sel, mem_req, mem_ready;

   logic        stall_front, stall_back, flush_id, flush_ex, mem_timeout_err;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] perf_stall_cnt;

   logic        il_stall_front, il_stall_back, il_flush_id, il_flush_ex, il_mem_timeout_err;
   logic [1:0]  il_fwd_a_sel, il_fwd_b_sel;
   logic [31:0] il_perf_stall_cnt;

   logic [7:0]  vec, il_vec;
   assign vec    = {stall_front, stall_back, flush_id, flush_ex, fwd_a_sel, fwd_b_sel};
   assign il_vec = {il_stall_front, il_stall_back, il_flush_id, il_flush_ex, il_fwd_a_sel, il_fwd_b_sel};

   exp_t        sb[$];
   exp_t        e;
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_perf = 0;

   hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .ex_pc_sel(ex_pc_sel), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_front(stall_front), .stall_back(stall_back), .flush_id(flush_id), .flush_ex(flush_ex),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_timeout_err(mem_timeout_err), .perf_stall_cnt(perf_stall_cnt)
   );

   hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(15)) dut_il (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .ex_pc_sel(ex_pc_sel), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_front(il_stall_front), .stall_back(il_stall_back), .flush_id(il_flush_id), .flush_ex(il_flush_ex),
      .fwd_a_sel(il_fwd_a_sel), .fwd_b_sel(il_fwd_b_sel),
      .mem_timeout_err(il_mem_timeout_err), .perf_stall_cnt(il_perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pk(input logic sf, input logic sbk, input logic fi,
                                      input logic fe, input logic [1:0] a, input logic [1:0] b);
      return {24'd0, sf, sbk, fi, fe, a, b};
   endfunction

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      ex_regwrite = 0; ex_is_load = 0; mem_regwrite = 0; wb_regwrite = 0;
      ex_pc_sel = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_use_inputs();
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 3; id_rs2 = 3;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      @(negedge clk);
      sb.push_back('{"rst_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"rst_err", 32'd0});
      sb.push_back('{"rst_perf", 32'd0});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      load_use_inputs();
      sb.push_back('{"rst_comb_vec", pk(1,0,0,1,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      tick();
      sb.push_back('{"rst_perf_held", 32'd0});
      #1;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      idle();
      rst = 0;
      exp_perf = 0;
      tick();
   endtask

   task automatic test_forwarding();
      logic [4:0] mrd[4]   = '{5'd5, 5'd0, 5'd5, 5'd5};
      logic       mwe[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [4:0] wrd[4]   = '{5'd5, 5'd0, 5'd5, 5'd9};
      logic [4:0] rs2[4]   = '{5'd9, 5'd5, 5'd5, 5'd9};
      logic [1:0] ea[4]    = '{2'b10, 2'b00, 2'b01, 2'b10};
      logic [1:0] eb[4]    = '{2'b00, 2'b00, 2'b01, 2'b01};
      for (int i = 0; i < 4; i++) begin
         idle();
         ex_rs1 = 5; ex_rs2 = rs2[i];
         mem_rd = mrd[i]; mem_regwrite = mwe[i];
         wb_rd = wrd[i]; wb_regwrite = 1;
         sb.push_back('{$sformatf("fwd_vec_%0d", i), pk(0,0,0,0,ea[i],eb[i])});
         sb.push_back('{$sformatf("fwd_il_vec_%0d", i), pk(0,0,0,0,2'b00,2'b00)});
         #1;
         e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
         e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
         tick();
      end
      idle();
   endtask

   task automatic test_load_use();
      idle();
      load_use_inputs();
      sb.push_back('{"lu_vec", pk(1,0,0,1,2'b00,2'b00)});
      sb.push_back('{"lu_il_vec", pk(1,0,0,1,2'b00,2'b00)});
      sb.push_back('{"lu_perf_before", exp_perf});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      exp_perf++;
      tick();
      idle();
      sb.push_back('{"lu_after_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"lu_perf_after", exp_perf});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      tick();
      ex_is_load = 1; ex_regwrite = 1; ex_rd = 0; id_rs2 = 0;
      sb.push_back('{"lu_r0_vec", pk(0,0,0,0,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      tick();
      idle();
   endtask

   task automatic test_interlock();
      idle();
      wb_rd = 7; wb_regwrite = 1; id_rs1 = 7; ex_rs1 = 7;
      sb.push_back('{"il_wb_vec", pk(1,0,0,1,2'b00,2'b00)});
      sb.push_back('{"il_fwd_build_vec", pk(0,0,0,0,2'b01,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      tick();
      idle();
      mem_rd = 4; mem_regwrite = 1; id_rs2 = 4;
      sb.push_back('{"il_mem_vec", pk(1,0,0,1,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
      tick();
      idle();
      wb_rd = 0; wb_regwrite = 1; id_rs1 = 0;
      sb.push_back('{"il_r0_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"il_perf_unchanged", exp_perf});
      #1;
      e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      tick();
      idle();
   endtask

   task automatic test_branch();
      idle();
      load_use_inputs();
      ex_pc_sel = 1;
      sb.push_back('{"br_vec", pk(0,0,1,1,2'b00,2'b00)});
      sb.push_back('{"br_il_vec", pk(0,0,1,1,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(il_vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_vec, e.val); else n_pass++;
      tick();
      idle();
      sb.push_back('{"br_perf", exp_perf});
      #1;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      tick();
   endtask

   task automatic test_mem_wait();
      idle();
      mem_req = 1; ex_pc_sel = 1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{$sformatf("mw_stall_%0d", i), pk(1,1,0,0,2'b00,2'b00)});
         #1;
         e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
         exp_perf++;
         tick();
      end
      mem_ready = 1;
      sb.push_back('{"mw_release_vec", pk(0,0,1,1,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      tick();
      idle();
      sb.push_back('{"mw_run_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"mw_perf", exp_perf});
      sb.push_back('{"mw_err", 32'd0});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      idle();
      mem_req = 1;
      for (int i = 1; i <= 5; i++) begin
         sb.push_back('{$sformatf("to_stall_%0d", i), pk(1,1,0,0,2'b00,2'b00)});
         sb.push_back('{$sformatf("to_err_low_%0d", i), 32'd0});
         #1;
         e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
         e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
         exp_perf++;
         tick();
      end
      mem_req = 0; mem_ready = 1;
      sb.push_back('{"to_err_set", 32'd1});
      sb.push_back('{"to_released_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"to_il_err", 32'd0});
      sb.push_back('{"to_perf", exp_perf});
      #1;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(il_mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, il_mem_timeout_err, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      tick();
      idle();
      tick(); tick();
      sb.push_back('{"to_err_sticky", 32'd1});
      #1;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      idle();
      mem_req = 1;
      tick(); tick();
      mem_req = 0;
      sb.push_back('{"rw_waiting_vec", pk(1,1,0,0,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      rst = 1;
      sb.push_back('{"rw_rst_vec", pk(0,0,0,0,2'b00,2'b00)});
      sb.push_back('{"rw_rst_err", 32'd0});
      sb.push_back('{"rw_rst_perf", 32'd0});
      #1;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (perf_stall_cnt !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, perf_stall_cnt, e.val); else n_pass++;
      tick();
      rst = 0;
      for (int i = 0; i < 6; i++) tick();
      sb.push_back('{"rw_err_after", 32'd0});
      sb.push_back('{"rw_vec_after", pk(0,0,0,0,2'b00,2'b00)});
      #1;
      e = sb.pop_front(); n_total++; if (32'(mem_timeout_err) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, mem_timeout_err, e.val); else n_pass++;
      e = sb.pop_front(); n_total++; if (32'(vec) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, vec, e.val); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_interlock();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
